// File: rtl/flash_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// flash_rd_ctrl_if
// Requester-side bus of the flash read controller. The toggle handshake is
// used: a request is pending while ireq != oack, and the controller
// answers one pending request by toggling oack once the read word is on
// odata.
//
// Signals
//   ireq    requester -> controller  toggle request
//   iaddr   requester -> controller  word address [23:1]; bit 23 is ignored
//   odata   controller -> requester  read word, even byte in bits [15:8]
//   oack    controller -> requester  toggle acknowledge
//   oready  controller -> requester  flash reset and recovery are complete
//
// Modports
//   master  requester side
//   slave   controller side
// ---------------------------------------------------------------------------
interface flash_rd_ctrl_if;
    logic        ireq;
    logic [23:1] iaddr;
    logic [15:0] odata;
    logic        oack;
    logic        oready;

    modport master (output ireq, iaddr, input odata, oack, oready);
    modport slave  (input ireq, iaddr, output odata, oack, oready);
endinterface

// File: rtl/flash_rd_ctrl.sv
// ---------------------------------------------------------------------------
// flash_rd_ctrl
// Read-only controller for an 8-bit parallel NOR flash. After reset it
// pulses the flash reset pin and waits out the recovery time. It then
// serves 16-bit word reads as two byte accesses: the even byte first,
// which becomes the high half, then the odd byte. Each byte address is
// held for WAIT_CYCLES+1 cycles before the data bus is sampled.
//
// Parameters
//   WAIT_CYCLES  extra cycles each byte address is held (0..255)
//   RST_CYCLES   cycles of flash reset-low and of recovery (1..65535)
//
// Ports
//   iclk       system clock
//   ireset     synchronous, active-high reset
//   bus        requester handshake (flash_rd_ctrl_if, slave side)
//   ofl_addr   flash byte address
//   ifl_dq     flash data bus
//   ofl_ce_n   chip enable, low only while a word read is in progress
//   ofl_oe_n   output enable, low only while a word read is in progress
//   ofl_we_n   write enable, held high
//   ofl_rst_n  flash reset, low during the reset-low phase
//   ofl_wp_n   write protect, held low
// ---------------------------------------------------------------------------
module flash_rd_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int RST_CYCLES  = 25
) (
    input  logic            iclk,
    input  logic            ireset,
    flash_rd_ctrl_if.slave  bus,
    output logic [22:0]     ofl_addr,
    input  logic [7:0]      ifl_dq,
    output logic            ofl_ce_n,
    output logic            ofl_oe_n,
    output logic            ofl_we_n,
    output logic            ofl_rst_n,
    output logic            ofl_wp_n
);

    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_LOW,
        RST_REC,
        IDLE,
        RD_HI,
        RD_LO
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] rst_cnt_q,  rst_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  hi_byte_q,  hi_byte_d;
    logic [15:0] odata_q,    odata_d;
    logic        oack_q,     oack_d;
    logic        oready_q,   oready_d;
    logic [22:0] addr_q,     addr_d;
    logic        ce_n_q,     ce_n_d;
    logic        oe_n_q,     oe_n_d;
    logic        rst_n_q,    rst_n_d;

    // The top address bit selects nothing on this flash.
    logic unused_iaddr_msb;
    assign unused_iaddr_msb = bus.iaddr[23];

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        wait_cnt_d = wait_cnt_q;
        hi_byte_d  = hi_byte_q;
        odata_d    = odata_q;
        oack_d     = oack_q;
        oready_d   = oready_q;
        addr_d     = addr_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        rst_n_d    = rst_n_q;

        case (state_q)
            RST_LOW: begin
                rst_n_d = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    rst_n_d   = 1'b1;
                    state_d   = RST_REC;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end

            // Requests arriving here stay pending and are picked up by
            // the first IDLE edge.
            RST_REC: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    oready_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end

            IDLE: begin
                if (bus.ireq != oack_q) begin
                    addr_d     = {bus.iaddr[22:1], 1'b0};
                    ce_n_d     = 1'b0;
                    oe_n_d     = 1'b0;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = RD_HI;
                end
            end

            RD_HI: begin
                if (wait_cnt_q == 8'd0) begin
                    hi_byte_d  = ifl_dq;
                    addr_d[0]  = 1'b1;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = RD_LO;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            // odata and oack change on the same edge, so the word is
            // already valid when the requester sees the toggle.
            RD_LO: begin
                if (wait_cnt_q == 8'd0) begin
                    odata_d = {hi_byte_q, ifl_dq};
                    oack_d  = ~oack_q;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                state_d = RST_LOW;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q    <= RST_LOW;
            rst_cnt_q  <= '0;
            wait_cnt_q <= '0;
            hi_byte_q  <= '0;
            odata_q    <= '0;
            oack_q     <= 1'b0;
            oready_q   <= 1'b0;
            addr_q     <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            rst_n_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            hi_byte_q  <= hi_byte_d;
            odata_q    <= odata_d;
            oack_q     <= oack_d;
            oready_q   <= oready_d;
            addr_q     <= addr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            rst_n_q    <= rst_n_d;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.oack   = oack_q;
    assign bus.oready = oready_q;
    assign ofl_addr   = addr_q;
    assign ofl_ce_n   = ce_n_q;
    assign ofl_oe_n   = oe_n_q;
    assign ofl_rst_n  = rst_n_q;
    assign ofl_we_n   = 1'b1;
    assign ofl_wp_n   = 1'b0;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flash_rd_ctrl
// Bench for flash_rd_ctrl with WAIT_CYCLES=4 and RST_CYCLES=25. A flash
// model drives ifl_dq only once the byte address has been stable long
// enough; expected words go into a scoreboard queue when a request is
// issued and are compared against odata when oack toggles.
// ---------------------------------------------------------------------------
module tb_flash_rd_ctrl;

    localparam int WAIT = 4;
    localparam int RSTC = 25;

    logic        clk = 1'b0;
    logic        ireset;
    logic [22:0] fl_addr;
    logic [7:0]  fl_dq;
    logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n, fl_wp_n;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        tb_ack = 1'b0;
    logic [15:0] sb[$];

    flash_rd_ctrl_if bus();

    flash_rd_ctrl #(.WAIT_CYCLES(WAIT), .RST_CYCLES(RSTC)) dut (
        .iclk      (clk),
        .ireset    (ireset),
        .bus       (bus),
        .ofl_addr  (fl_addr),
        .ifl_dq    (fl_dq),
        .ofl_ce_n  (fl_ce_n),
        .ofl_oe_n  (fl_oe_n),
        .ofl_we_n  (fl_we_n),
        .ofl_rst_n (fl_rst_n),
        .ofl_wp_n  (fl_wp_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- flash model ----------------
    function automatic logic [7:0] flash_byte(input logic [22:0] a);
        if (a == 23'd0) return 8'h12;
        if (a == 23'd1) return 8'h34;
        return a[7:0] ^ {a[14:8], 1'b1} ^ {1'b0, a[22:16]} ^ 8'hA5;
    endfunction

    function automatic logic [15:0] exp_word(input logic [23:1] a);
        return {flash_byte({a[22:1], 1'b0}), flash_byte({a[22:1], 1'b1})};
    endfunction

    // Data is valid only after the address has been held for WAIT edges.
    logic [22:0] last_addr = '0;
    int          age = 0;
    always @(posedge clk) begin
        if (fl_addr !== last_addr) age <= 0;
        else if (age < 1000) age <= age + 1;
        last_addr <= fl_addr;
    end
    assign fl_dq = (fl_ce_n === 1'b0 && fl_oe_n === 1'b0 && age >= WAIT - 1)
                   ? flash_byte(fl_addr) : 8'hEE;

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        prev_ack;
        logic [15:0] prev_data;
        logic [15:0] exp;
        prev_ack  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (ireset !== 1'b0) begin
                prev_ack  = bus.oack;
                prev_data = bus.odata;
            end else if (bus.oack !== prev_ack) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_ack: got odata=%h, want no ack", bus.odata);
                end else begin
                    exp = sb.pop_front();
                    if (bus.odata !== exp) begin
                        miscompares++;
                        $display("FAIL sb_word: got %h, want %h", bus.odata, exp);
                    end
                end
                prev_ack  = bus.oack;
                prev_data = bus.odata;
            end else begin
                vectors++;
                if (bus.odata !== prev_data) begin
                    miscompares++;
                    $display("FAIL odata_stable: got %h, want %h", bus.odata, prev_data);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    // Called just after a negedge; the next posedge is the expected E0.
    task automatic issue(input logic [23:1] a, output int e0);
        bus.ireq  = ~bus.ireq;
        bus.iaddr = a;
        sb.push_back(exp_word(a));
        e0 = cyc + 1;
    endtask

    task automatic wait_ack(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.oack !== tb_ack) begin
                tb_ack = bus.oack;
                at = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL %s ack_timeout: got no ack, want ack within 60 cycles", tag);
    endtask

    task automatic check_reset_values(input string tag);
        vectors += 7;
        if (fl_rst_n !== 1'b0) begin miscompares++; $display("FAIL %s rst_n: got %b, want 0", tag, fl_rst_n); end
        if (fl_ce_n !== 1'b1 || fl_oe_n !== 1'b1) begin miscompares++; $display("FAIL %s ce_oe: got %b%b, want 11", tag, fl_ce_n, fl_oe_n); end
        if (bus.oack !== 1'b0) begin miscompares++; $display("FAIL %s oack: got %b, want 0", tag, bus.oack); end
        if (bus.odata !== 16'h0000) begin miscompares++; $display("FAIL %s odata: got %h, want 0000", tag, bus.odata); end
        if (bus.oready !== 1'b0) begin miscompares++; $display("FAIL %s oready: got %b, want 0", tag, bus.oready); end
        if (fl_addr !== 23'd0) begin miscompares++; $display("FAIL %s addr: got %h, want 0", tag, fl_addr); end
        if (fl_we_n !== 1'b1 || fl_wp_n !== 1'b0) begin miscompares++; $display("FAIL %s we_wp: got %b%b, want 10", tag, fl_we_n, fl_wp_n); end
    endtask

    // Called at the negedge after the last reset edge; releases ireset and
    // follows the reset-low and recovery phases.
    task automatic check_reset_seq(input string tag, input bit pend, output int base);
        int e0;
        base = cyc;
        ireset = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            vectors += 4;
            if (fl_rst_n !== (k >= RSTC)) begin miscompares++; $display("FAIL %s rst_n k=%0d: got %b, want %b", tag, k, fl_rst_n, k >= RSTC); end
            if (bus.oready !== (k >= 2 * RSTC)) begin miscompares++; $display("FAIL %s oready k=%0d: got %b, want %b", tag, k, bus.oready, k >= 2 * RSTC); end
            if (bus.oack !== 1'b0) begin miscompares++; $display("FAIL %s oack k=%0d: got %b, want 0", tag, k, bus.oack); end
            if (fl_ce_n !== !(pend && k >= 2 * RSTC + 1)) begin miscompares++; $display("FAIL %s ce_n k=%0d: got %b, want %b", tag, k, fl_ce_n, !(pend && k >= 2 * RSTC + 1)); end
            if (pend && k == 30) issue(23'd5, e0);
        end
    endtask

    task automatic read_and_check(input logic [23:1] a, input string tag);
        logic [22:0] even;
        logic [22:0] exp_addr;
        logic        start_ack;
        int          e0;
        even      = {a[22:1], 1'b0};
        start_ack = tb_ack;
        issue(a, e0);
        for (int k = 0; k <= 2 * WAIT + 2; k++) begin
            @(negedge clk);
            exp_addr = (k <= WAIT) ? even : (even | 23'd1);
            vectors += 3;
            if (fl_addr !== exp_addr) begin miscompares++; $display("FAIL %s addr k=%0d: got %h, want %h", tag, k, fl_addr, exp_addr); end
            if (fl_ce_n !== (k == 2 * WAIT + 2) || fl_oe_n !== (k == 2 * WAIT + 2)) begin miscompares++; $display("FAIL %s ce_oe k=%0d: got %b%b, want %b", tag, k, fl_ce_n, fl_oe_n, k == 2 * WAIT + 2); end
            if (bus.oack !== ((k == 2 * WAIT + 2) ? ~start_ack : start_ack)) begin miscompares++; $display("FAIL %s oack k=%0d: got %b", tag, k, bus.oack); end
        end
        tb_ack = ~start_ack;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int base;
        int at;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        check_reset_seq("reset", 1'b1, base);
        wait_ack("reset_pending", at);
        vectors++;
        if (at !== base + 2 * RSTC + 1 + 2 * WAIT + 2) begin
            miscompares++;
            $display("FAIL reset_pending ack_cycle: got %0d, want %0d", at, base + 2 * RSTC + 1 + 2 * WAIT + 2);
        end
    endtask

    task automatic test_single_read();
        read_and_check(23'd0, "single");
        vectors++;
        if (bus.odata !== 16'h1234) begin miscompares++; $display("FAIL single odata: got %h, want 1234", bus.odata); end
    endtask

    task automatic test_top_address();
        read_and_check(23'h3FFFFF, "top");
        read_and_check(23'h7FFFFF, "top_a23");
    endtask

    task automatic test_back_to_back();
        int e0;
        int at;
        int prev;
        issue(23'd0, e0);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack("b2b", at);
            vectors++;
            if (i == 0 && at !== e0 + 2 * WAIT + 2) begin
                miscompares++;
                $display("FAIL b2b first_ack: got %0d, want %0d", at, e0 + 2 * WAIT + 2);
            end else if (i > 0 && at - prev !== 2 * WAIT + 3) begin
                miscompares++;
                $display("FAIL b2b spacing %0d: got %0d, want %0d", i, at - prev, 2 * WAIT + 3);
            end
            prev = at;
            if (i < 3) issue(23'(i + 1), e0);
        end
    endtask

    task automatic test_early_toggle();
        logic [23:1] a_addr;
        logic [23:1] b_addr;
        int          e0;
        int          dummy;
        int          at;
        a_addr = 23'h012345;
        b_addr = 23'h054321;
        issue(a_addr, e0);
        for (int k = 0; k <= 2 * WAIT + 3; k++) begin
            @(negedge clk);
            if (k == 2) bus.iaddr = 23'h2AAAAA;
            if (k == 3) begin
                vectors++;
                if (fl_addr !== {a_addr[22:1], 1'b0}) begin miscompares++; $display("FAIL early addr_hold: got %h, want %h", fl_addr, {a_addr[22:1], 1'b0}); end
            end
            if (k == WAIT + 2) begin
                vectors++;
                if (fl_addr !== {a_addr[22:1], 1'b1}) begin miscompares++; $display("FAIL early rd_lo_addr: got %h, want %h", fl_addr, {a_addr[22:1], 1'b1}); end
                issue(b_addr, dummy);
            end
            if (k == 2 * WAIT + 2) begin
                vectors += 2;
                if (bus.oack === tb_ack) begin miscompares++; $display("FAIL early a_ack: got %b, want %b", bus.oack, ~tb_ack); end
                if (fl_ce_n !== 1'b1) begin miscompares++; $display("FAIL early a_ce_n: got %b, want 1", fl_ce_n); end
                tb_ack = bus.oack;
            end
            if (k == 2 * WAIT + 3) begin
                vectors += 2;
                if (fl_ce_n !== 1'b0) begin miscompares++; $display("FAIL early b_start: got ce_n=%b, want 0", fl_ce_n); end
                if (fl_addr !== {b_addr[22:1], 1'b0}) begin miscompares++; $display("FAIL early b_addr: got %h, want %h", fl_addr, {b_addr[22:1], 1'b0}); end
            end
        end
        wait_ack("early_b", at);
        vectors++;
        if (at !== e0 + 2 * (2 * WAIT + 2) + 1) begin
            miscompares++;
            $display("FAIL early b_ack_cycle: got %0d, want %0d", at, e0 + 2 * (2 * WAIT + 2) + 1);
        end
    endtask

    task automatic test_reset_mid_access();
        int e0;
        int base;
        vectors++;
        if (bus.oack !== 1'b0) begin miscompares++; $display("FAIL midrst pre_oack: got %b, want 0", bus.oack); end
        issue(23'd7, e0);
        @(negedge clk);
        @(negedge clk);
        ireset   = 1'b1;
        bus.ireq = 1'b0;
        tb_ack   = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        check_reset_seq("midrst", 1'b0, base);
        read_and_check(23'd2, "after_midrst");
    endtask

    initial begin
        ireset    = 1'b1;
        bus.ireq  = 1'b0;
        bus.iaddr = '0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_top_address();
        test_back_to_back();
        test_early_toggle();
        test_reset_mid_access();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d words pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
